// File: rtl/imm_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_enc_pkg
// Purpose  : Shared constants, request encodings, FSM state type and
//            RV32I field-packing helpers for the immediate encoder.
// Revision : 1.0 - initial release
// ============================================================================
package imm_enc_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3 values
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SW   = 3'b010;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Request opcodes on in_op (2'b11 is reserved)
  localparam logic [1:0] REQ_LI   = 2'b00;
  localparam logic [1:0] REQ_ADDI = 2'b01;
  localparam logic [1:0] REQ_SW   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  // I-type ADDI: {imm12, rs1, funct3, rd, opcode}
  function automatic logic [31:0] enc_addi(input logic [11:0] imm12,
                                           input logic [4:0]  rs1,
                                           input logic [4:0]  rd);
    return {imm12, rs1, F3_ADDI, rd, OP_IMM};
  endfunction

  // U-type LUI: {hi20, rd, opcode}
  function automatic logic [31:0] enc_lui(input logic [19:0] hi20,
                                          input logic [4:0]  rd);
    return {hi20, rd, OP_LUI};
  endfunction

  // S-type SW: immediate split around the register fields
  function automatic logic [31:0] enc_sw(input logic [11:0] imm12,
                                         input logic [4:0]  rs2,
                                         input logic [4:0]  rs1);
    return {imm12[11:5], rs2, rs1, F3_SW, imm12[4:0], OP_STORE};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_split.sv
`default_nettype none
// ============================================================================
// Module   : imm_split
// Purpose  : Combinational immediate analysis for a 32-bit value.
// Ports    : value   - 32-bit two's complement immediate
//            fits12  - value is representable as a sign-extended 12-bit imm
//            hi20    - upper 20 bits rounded so that (hi20<<12)+sext(lo12)
//                      reconstructs value
//            lo12    - low 12 bits of value
//            lo_zero - lo12 is zero (LUI alone is sufficient)
// Revision : 1.0 - initial release
// ============================================================================
module imm_split (
  input  logic [31:0] value,
  output logic        fits12,
  output logic [19:0] hi20,
  output logic [11:0] lo12,
  output logic        lo_zero
);

  logic [20:0] top_bits;

  assign top_bits = value[31:11];
  assign fits12   = (top_bits == 21'h0) || (top_bits == 21'h1F_FFFF);
  assign lo12     = value[11:0];
  assign lo_zero  = (value[11:0] == 12'h000);
  // (value + 0x800) >> 12: adding 0x800 carries into bit 12 exactly when
  // bit 11 is set, so the low bits of the sum never need to be formed.
  assign hi20     = value[31:12] + {19'b0, value[11]};

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Sequential RV32I immediate encoder. Turns {op, rd, rs1, value}
//            requests into one or two instruction words (LI, ADDI, SW),
//            streamed over a valid/ready handshake.
// Ports    : clk, rstn (async, active-low)
//            in_valid/in_ready, in_op, in_rd, in_rs1, in_value - request
//            out_valid/out_ready, out_instr, out_last, out_err   - words
//            instr_count - number of accepted output words (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic             out_err,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [31:0]      second_q, second_d;   // pending LI ADDI word
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        fits12, lo_zero;
  logic [19:0] hi20;
  logic [11:0] lo12;

  logic [31:0] first_word, second_word;
  logic        first_err, has_second;
  logic        accept, out_hs;

  imm_split u_split (
    .value   (in_value),
    .fits12  (fits12),
    .hi20    (hi20),
    .lo12    (lo12),
    .lo_zero (lo_zero)
  );

  // Handshake qualifiers depend only on registered state and rstn.
  assign in_ready  = rstn && (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Words for the request currently presented on the input.
  always_comb begin
    first_word  = NOP_INSTR;
    first_err   = 1'b0;
    second_word = NOP_INSTR;
    has_second  = 1'b0;
    unique case (in_op)
      REQ_LI: begin
        if (fits12) begin
          first_word = enc_addi(lo12, 5'd0, in_rd);
        end else begin
          first_word = enc_lui(hi20, in_rd);
          if (!lo_zero) begin
            second_word = enc_addi(lo12, in_rd, in_rd);
            has_second  = 1'b1;
          end
        end
      end
      REQ_ADDI: begin
        if (fits12) first_word = enc_addi(lo12, in_rs1, in_rd);
        else        first_err  = 1'b1;
      end
      REQ_SW: begin
        if (fits12) first_word = enc_sw(lo12, in_rd, in_rs1);
        else        first_err  = 1'b1;
      end
      default: first_err = 1'b1;
    endcase
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    last_d   = last_q;
    err_d    = err_q;
    second_d = second_q;
    pend_d   = pend_q;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, out_hs};
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d  = first_word;
          last_d   = !has_second;
          err_d    = first_err;
          second_d = second_word;
          pend_d   = has_second;
          state_d  = EMIT1;
        end
      end
      EMIT1: begin
        if (out_hs) begin
          if (pend_q) begin
            instr_d = second_q;
            last_d  = 1'b1;
            err_d   = 1'b0;
            pend_d  = 1'b0;
            state_d = EMIT2;
          end else begin
            state_d = IDLE;
          end
        end
      end
      EMIT2: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      instr_q  <= 32'h0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      second_q <= 32'h0;
      pend_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      last_q   <= last_d;
      err_q    <= err_d;
      second_q <= second_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
    end
  end

  assign out_instr   = instr_q;
  assign out_last    = last_q;
  assign out_err     = err_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encoder
// Purpose  : Self-checking bench for imm_encoder with an expected-word queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [31:0] in_value = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;
  logic [15:0] instr_count;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_value    (in_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_last    (out_last),
    .out_err     (out_err),
    .instr_count (instr_count)
  );

  // ---------------- reference encoding model ----------------
  function automatic logic [31:0] m_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] m_u(input logic [19:0] hi, input logic [4:0] rd);
    return {hi, rd, 7'h37};
  endfunction
  function automatic logic [31:0] m_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  task automatic model(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] v);
    int          sv;
    bit          fits;
    logic [31:0] hi;
    sv   = $signed(v);
    fits = (sv >= -2048) && (sv <= 2047);
    hi   = (v + 32'd2048) >> 12;
    case (op)
      2'b00: begin
        if (fits) sb.push_back(exp_t'{m_i(v[11:0], 5'd0, rd), 1'b1, 1'b0});
        else begin
          sb.push_back(exp_t'{m_u(hi[19:0], rd), (v[11:0] == 12'h0), 1'b0});
          if (v[11:0] != 12'h0) sb.push_back(exp_t'{m_i(v[11:0], rd, rd), 1'b1, 1'b0});
        end
      end
      2'b01: sb.push_back(fits ? exp_t'{m_i(v[11:0], rs1, rd), 1'b1, 1'b0} : exp_t'{32'h13, 1'b1, 1'b1});
      2'b10: sb.push_back(fits ? exp_t'{m_s(v[11:0], rd, rs1), 1'b1, 1'b0} : exp_t'{32'h13, 1'b1, 1'b1});
      default: sb.push_back(exp_t'{32'h13, 1'b1, 1'b1});
    endcase
  endtask

  // Presents a request from a negedge; returns #1 after the accepting edge
  // with the inputs scrambled so only the sampled values can matter.
  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] v);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_value = v;
    while (in_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op    = 2'($urandom);
      in_rd    = 5'($urandom);
      in_rs1   = 5'($urandom);
      in_value = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0 || out_err !== 1'b0 ||
        instr_count !== 16'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b instr=%h last=%b err=%b cnt=%0d ready=%b, required all 0",
               out_valid, out_instr, out_last, out_err, instr_count, in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: ready=%b valid=%b, required ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  // Test-plan vectors, issued back to back with out_ready held high.
  task automatic test_vectors();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin sb.push_back(exp_t'{32'h12300293, 1'b1, 1'b0}); send(2'b00, 5'd5, 5'd9, 32'h00000123); end
        1: begin sb.push_back(exp_t'{32'h123450B7, 1'b0, 1'b0});
                 sb.push_back(exp_t'{32'h67808093, 1'b1, 1'b0}); send(2'b00, 5'd1, 5'd0, 32'h12345678); end
        2: begin sb.push_back(exp_t'{32'h80000137, 1'b0, 1'b0});
                 sb.push_back(exp_t'{32'h80010113, 1'b1, 1'b0}); send(2'b00, 5'd2, 5'd0, 32'h7FFFF800); end
        3: begin sb.push_back(exp_t'{32'h000051B7, 1'b1, 1'b0}); send(2'b00, 5'd3, 5'd0, 32'h00005000); end
        4: begin sb.push_back(exp_t'{32'hFE612E23, 1'b1, 1'b0}); send(2'b10, 5'd6, 5'd2, 32'hFFFFFFFC); end
        5: begin sb.push_back(exp_t'{32'h00000013, 1'b1, 1'b1}); send(2'b01, 5'd1, 5'd1, 32'h00001000); end
        default: begin sb.push_back(exp_t'{32'h00000013, 1'b1, 1'b1}); send(2'b11, 5'd4, 5'd4, 32'h0); end
      endcase
      while (sb.size() > 0) begin
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== e.instr || out_last !== e.last || out_err !== e.err) begin
          failures++;
          $display("FAIL vec%0d_word: valid=%b instr=%h last=%b err=%b, required valid=1 instr=%h last=%b err=%b",
                   i, out_valid, out_instr, out_last, out_err, e.instr, e.last, e.err);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL vec%0d_busy_ready: in_ready=%b, required 0", i, in_ready);
        end
        @(posedge clk);
        exp_count++;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_count !== exp_count) begin
        failures++;
        $display("FAIL vec%0d_done: valid=%b ready=%b cnt=%0d, required valid=0 ready=1 cnt=%0d",
                 i, out_valid, in_ready, instr_count, exp_count);
      end
    end
  endtask

  // Stall on the second LI word: word stable, no accept, count frozen.
  task automatic test_backpressure();
    send(2'b00, 5'd1, 5'd0, 32'h12345678);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h123450B7 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL bp_first: valid=%b instr=%h last=%b, required 1 123450b7 0", out_valid, out_instr, out_last);
    end
    @(posedge clk);
    exp_count++;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h67808093 || out_last !== 1'b1 || out_err !== 1'b0 ||
          in_ready !== 1'b0 || instr_count !== exp_count) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b instr=%h last=%b err=%b ready=%b cnt=%0d, required 1 67808093 1 0 0 %0d",
                 k, out_valid, out_instr, out_last, out_err, in_ready, instr_count, exp_count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    exp_count++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_count !== exp_count) begin
      failures++;
      $display("FAIL bp_release: valid=%b ready=%b cnt=%0d, required 0 1 %0d", out_valid, in_ready, instr_count, exp_count);
    end
  endtask

  // Reset in the middle of a pair, then a clean request afterwards.
  task automatic test_reset_mid_pair();
    send(2'b00, 5'd2, 5'd0, 32'h7FFFF800);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0 || out_err !== 1'b0 ||
        instr_count !== 16'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b instr=%h last=%b err=%b cnt=%0d ready=%b, required all 0",
               out_valid, out_instr, out_last, out_err, instr_count, in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    exp_count = 16'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_quiet%0d: valid=%b, required 0", k, out_valid);
      end
    end
    send(2'b00, 5'd5, 5'd0, 32'h00000123);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h12300293 || out_last !== 1'b1 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_req: valid=%b instr=%h last=%b err=%b, required 1 12300293 1 0",
               out_valid, out_instr, out_last, out_err);
    end
    @(posedge clk);
    exp_count++;
    @(negedge clk);
    checks++;
    if (instr_count !== exp_count || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_cnt: cnt=%0d valid=%b, required %0d 0", instr_count, out_valid, exp_count);
    end
  endtask

  // Boundary values first, then random requests, all checked against the model.
  task automatic test_random();
    exp_t        e;
    logic [31:0] v;
    logic [1:0]  op;
    logic [4:0]  rd, rs1;
    logic [31:0] bnd[8] = '{32'h000007FF, 32'hFFFFF800, 32'h00000800, 32'hFFFFF7FF,
                             32'h80000000, 32'h7FFFFFFF, 32'hFFFFF000, 32'h00000000};
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom);
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      if (i < 8)                v = bnd[i];
      else if (i % 3 == 0)      v = 32'($signed(12'($urandom)));
      else if (i % 3 == 1)      v = {20'($urandom), 12'h000};
      else                      v = $urandom;
      if (i < 8) op = 2'(i % 3);
      model(op, rd, rs1, v);
      send(op, rd, rs1, v);
      while (sb.size() > 0) begin
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== e.instr || out_last !== e.last || out_err !== e.err) begin
          failures++;
          $display("FAIL rand%0d op=%0d v=%h: valid=%b instr=%h last=%b err=%b, required valid=1 instr=%h last=%b err=%b",
                   i, op, v, out_valid, out_instr, out_last, out_err, e.instr, e.last, e.err);
        end
        @(posedge clk);
        exp_count++;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || instr_count !== exp_count) begin
        failures++;
        $display("FAIL rand%0d_done: valid=%b cnt=%0d, required 0 %0d", i, out_valid, instr_count, exp_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_pair();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
# imm_encoder

Sequential immediate encoder. It is the inverse of the immediate extender: it takes a full 32-bit value plus register fields and emits legal RV32I instruction words, with each immediate split into its I/S/U fields. Load-immediate expands to one or two instructions. It sits between the lab's program-loader/test-sequencer and the instruction memory write port, streaming words over a valid/ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of the emitted-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  2  00 LI, 01 ADDI, 10 SW, 11 reserved
- in_rd  in  5  rd (LI/ADDI) or rs2 (SW)
- in_rs1  in  5  rs1 (ADDI/SW); ignored for LI
- in_value  in  32  immediate value, two's complement
- out_valid  out  1  instruction word valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_instr  out  32  encoded instruction
- out_last  out  1  final word of the current request
- out_err  out  1  request rejected; word is NOP
- instr_count  out  CNT_W  count of accepted output words, wraps modulo 2^CNT_W

## Operation
- Encodings:
  - LUI = {hi20, rd, 0110111}
  - ADDI = {imm12, rs1, 000, rd, 0010011}
  - SW = {imm12[11:5], rs2, rs1, 010, imm12[4:0], 0100011}
  - NOP = 32'h00000013
- Fit test for 12 bits: in_value[31:11] all zeros or all ones.
- LI:
  - If the value fits 12 bits, emit one word: ADDI rd, x0, value[11:0].
  - Otherwise set hi20 = (in_value + 32'h800)[31:12] with 32-bit wrap, and lo = in_value[11:0].
  - Emit LUI rd, hi20. If lo != 0, follow it with ADDI rd, rd, lo. If lo == 0, LUI is the only and last word.
  - rd = x0 is encoded normally; no special case.
- ADDI: if the value fits 12 bits, emit ADDI rd, rs1, value[11:0]. Otherwise emit NOP with out_err=1.
- SW: if the value fits 12 bits, emit the SW encoding. Otherwise emit NOP with out_err=1.
- Reserved op: emit NOP with out_err=1.
- out_last=1 on every single-word response and on the second LI word.
- FSM states:
  - IDLE: in_ready=1. On accept, latch fields, load the first word into the output registers, go to EMIT1.
  - EMIT1: out_valid=1. On handshake: if a second word is pending, load it and go to EMIT2; otherwise go to IDLE.
  - EMIT2: out_valid=1, out_last=1. On handshake, go to IDLE.
- Input fields are sampled only at accept; later changes on in_* do not affect the words in flight.
- instr_count increments on each output handshake.

## Timing
- Reset (rstn low, asynchronous):
  - state=IDLE.
  - out_valid=0, out_instr=0, out_last=0, out_err=0, instr_count=0.
  - in_ready is forced 0 while rstn is low.
- Latency: a request accepted at edge N gives out_valid=1 in the cycle after edge N.
- In a two-word LI, the second word is valid in the cycle after the first handshake. There are no bubbles if out_ready stays high.
- No same-cycle reaccept: in_ready rises in the cycle after the last handshake. Minimum request period is 2 cycles (one word) or 3 cycles (two words).
- While out_valid=1 and out_ready=0, out_instr, out_last and out_err hold stable. out_valid never drops without a handshake.
- A reset asserted mid-request discards the pending words. No partial pair is emitted after reset releases.
- in_ready and out_valid depend only on registered state plus rstn. There is no combinational path from out_ready to in_ready.

## Structure
- Package imm_enc_pkg holds:
  - opcode constants OP_LUI, OP_IMM, OP_STORE
  - funct3 constants F3_ADDI, F3_SW
  - NOP_INSTR
  - the in_op encodings LI/ADDI/SW
  - the FSM state type: IDLE/EMIT1/EMIT2
- One combinational sub-module, imm_split, computes fits12, hi20, lo12 and lo_zero from in_value.
- Field packing and the FSM live in imm_encoder.

## Test plan
- LI x5, 32'h00000123 -> one word 32'h12300293, last=1, err=0.
- LI x1, 32'h12345678 -> 32'h123450B7 then 32'h67808093 (last on the second word); instr_count +2.
- LI x2, 32'h7FFFF800 (rounding wrap) -> 32'h80000137 then 32'h80010113.
- LI x3, 32'h00005000 (lo=0) -> single LUI 32'h000051B7, last=1.
- SW rs2=x6, rs1=x2, value 32'hFFFFFFFC -> 32'hFE612E23. Also ADDI with value 32'h00001000 -> 32'h00000013 with err=1, last=1.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles during the second LI word -> word stable, in_ready=0.
  - Assert rstn low mid-pair -> all outputs return to their reset values at once, and the next accepted request emits correctly.
